// File: rtl/fp_pkg.sv
// fp_pkg: flag bit positions, special-result codes, the stage-1 record and the canonical qNaN
// pattern shared by the fp_result_packer pipeline.
package fp_pkg;
   localparam int FP_EXP_W       = 8;
   localparam int FP_MANT_W      = 23;
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;
   typedef enum logic [2:0] {SP_FINITE, SP_ZERO, SP_INF, SP_QNAN, SP_INVALID} special_e;
   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W+1:0] exp;
      logic [FP_MANT_W:0]  sig;
      logic                inc;
      special_e            sp;
      logic                tiny;
      logic                inexact;
   } stage1_t;
   function automatic logic [63:0] qnan_bits(input int ew, input int mw);
      return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
   endfunction
endpackage

// File: rtl/fp_denorm_shift.sv
// fp_denorm_shift: right shifter that ORs every shifted-out bit into the result LSB (sticky).
// Only present when FP_PACK_DENORM_EN is defined.
`ifdef FP_PACK_DENORM_EN
module fp_denorm_shift #(
   parameter int W  = 27,
   parameter int SW = 11
) (
   input  logic [W-1:0]  i_data,
   input  logic [SW-1:0] i_shamt,
   output logic [W-1:0]  o_data
);
   logic [W-1:0] w_shifted, w_lost;
   assign w_shifted = i_data >> i_shamt;
   assign w_lost    = i_data & ~({W{1'b1}} << i_shamt);
   assign o_data    = {w_shifted[W-1:1], w_shifted[0] | (|w_lost)};
endmodule
`endif

// File: rtl/fp_result_packer.sv
// fp_result_packer: 2-stage valid/ready RNE round, range check and IEEE-754 pack of a product.
// Define FP_PACK_DENORM_EN for gradual underflow; otherwise tiny results flush to signed zero.
module fp_result_packer
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH  = FP_EXP_W,
   parameter int MANT_WIDTH = FP_MANT_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_sign,
   input  logic [EXP_WIDTH+1:0]          in_exp,
   input  logic [MANT_WIDTH+3:0]         in_mant,
   input  logic                          in_nan_operand,
   input  logic                          in_invalid,
   input  logic                          in_inf,
   input  logic                          in_zero,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [EXP_WIDTH+MANT_WIDTH:0] out_result,
   output logic [3:0]                    out_flags
);
   localparam int                   RES_W = EXP_WIDTH + MANT_WIDTH + 1;
   localparam logic [RES_W-1:0]     QNAN  = RES_W'(qnan_bits(EXP_WIDTH, MANT_WIDTH));
   localparam logic [EXP_WIDTH+2:0] EMAX  = (EXP_WIDTH+3)'((1 << EXP_WIDTH) - 1);

   logic                  w_advance, w_tiny, w_force_inexact, w_ovf, r_v1;
   logic [MANT_WIDTH+3:0] w_m;
   stage1_t               w_s1, r_s1;
   logic [MANT_WIDTH+1:0] w_round;
   logic [EXP_WIDTH+2:0]  w_exp_n;
   logic [EXP_WIDTH-1:0]  w_expf;
   logic [RES_W-1:0]      w_fin, w_result;
   logic [3:0]            w_fflags, w_flags;

   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;
   assign w_tiny    = in_exp[EXP_WIDTH+1] || (in_exp == '0);

`ifdef FP_PACK_DENORM_EN
   logic [EXP_WIDTH+2:0]  w_shamt;
   logic [MANT_WIDTH+3:0] w_shifted;
   assign w_shamt = (EXP_WIDTH+3)'(1) - {in_exp[EXP_WIDTH+1], in_exp};
   fp_denorm_shift #(.W(MANT_WIDTH+4), .SW(EXP_WIDTH+3)) u_shift (
      .i_data (in_mant),
      .i_shamt(w_shamt),
      .o_data (w_shifted)
   );
   assign w_m             = w_tiny ? w_shifted : in_mant;
   assign w_force_inexact = 1'b0;
`else
   // a flushed input enters stage 2 as a zero significand that is still tiny and inexact
   assign w_m             = w_tiny ? '0 : in_mant;
   assign w_force_inexact = w_tiny;
`endif

   always_comb begin
      w_s1         = '0;
      w_s1.sign    = in_sign;
      w_s1.exp     = w_tiny ? '0 : in_exp;
      w_s1.sig     = w_m[MANT_WIDTH+3:3];
      w_s1.inc     = w_m[2] && (w_m[1] || w_m[0] || w_m[3]);
      w_s1.tiny    = w_tiny;
      w_s1.inexact = w_force_inexact || (|w_m[2:0]);
      w_s1.sp      = (in_nan_operand || in_invalid) ? (in_invalid ? SP_INVALID : SP_QNAN) :
                     in_inf ? SP_INF : in_zero ? SP_ZERO : SP_FINITE;
   end

   // tiny results take their exponent field from the post-round hidden bit
   always_comb begin
      w_round                  = {1'b0, r_s1.sig} + (MANT_WIDTH+2)'(r_s1.inc);
      w_exp_n                  = {r_s1.exp[EXP_WIDTH+1], r_s1.exp} + (EXP_WIDTH+3)'(w_round[MANT_WIDTH+1]);
      w_ovf                    = !r_s1.tiny && ($signed(w_exp_n) >= $signed(EMAX));
      w_expf                   = r_s1.tiny ? EXP_WIDTH'(w_round[MANT_WIDTH]) : w_exp_n[EXP_WIDTH-1:0];
      w_fin                    = w_ovf ? {r_s1.sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}} :
                                         {r_s1.sign, w_expf, w_round[MANT_WIDTH-1:0]};
      w_fflags                 = '0;
      w_fflags[FLAG_OVERFLOW]  = w_ovf;
      w_fflags[FLAG_UNDERFLOW] = r_s1.tiny && r_s1.inexact;
      w_fflags[FLAG_INEXACT]   = r_s1.inexact || w_ovf;
      w_result                 = (r_s1.sp == SP_QNAN || r_s1.sp == SP_INVALID) ? QNAN :
                                 r_s1.sp == SP_INF  ? {r_s1.sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}} :
                                 r_s1.sp == SP_ZERO ? {r_s1.sign, {(RES_W-1){1'b0}}} : w_fin;
      w_flags                  = r_s1.sp == SP_INVALID ? 4'(1 << FLAG_INVALID) :
                                 r_s1.sp == SP_FINITE  ? w_fflags : 4'b0000;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_v1       <= 1'b0;
         r_s1       <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else if (w_advance) begin
         r_v1       <= in_valid;
         r_s1       <= w_s1;
         out_valid  <= r_v1;
         out_result <= w_result;
         out_flags  <= w_flags;
      end
endmodule

// File: tb/tb_fp_result_packer.sv
// tb_fp_result_packer: directed and randomized checks of fp_result_packer against an integer-arithmetic
// RNE model with an in-order scoreboard. Honours FP_PACK_DENORM_EN like the design.
`timescale 1ns/1ps
module tb_fp_result_packer;
   typedef struct packed {logic [31:0] res; logic [3:0] flg;} exp_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_sign = 1'b0, in_nan = 1'b0, in_inv = 1'b0, in_inf = 1'b0, in_zero = 1'b0;
   logic [9:0]  in_exp = '0;
   logic [26:0] in_mant = '0;
   logic        in_ready, out_valid, out_ready = 1'b1;
   logic [31:0] out_result;
   logic [3:0]  out_flags;
   int          n_checks = 0, n_fail = 0, n_out = 0;
   exp_t        q[$];
   logic        held = 1'b0, exp_stall = 1'b0;
   logic [35:0] held_val = '0;

   always #5 clk = ~clk;

   fp_result_packer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
      .in_exp(in_exp), .in_mant(in_mant), .in_nan_operand(in_nan), .in_invalid(in_inv),
      .in_inf(in_inf), .in_zero(in_zero), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic exp_t model(input logic s, input logic [9:0] e, input logic [26:0] m,
                                  input logic nan, input logic inv, input logic inf, input logic zero);
      exp_t   r;
      longint sig, q, rem;
      int     ex;
      sig   = longint'(m);
      ex    = int'($signed(e));
      r.flg = 4'b0000;
      r.res = 32'h0;
      if (nan || inv) begin
         r.res = 32'h7FC0_0000;
         r.flg = inv ? 4'b1000 : 4'b0000;
      end else if (inf) r.res = {s, 31'h7F80_0000};
      else if (zero) r.res = {s, 31'h0};
      else if (ex >= 1) begin
         q   = sig / 8;
         rem = sig % 8;
         if (rem > 4 || (rem == 4 && q % 2 == 1)) q++;
         if (q == (longint'(1) << 24)) begin
            q = q / 2;
            ex++;
         end
         if (ex >= 255) begin
            r.res = {s, 31'h7F80_0000};
            r.flg = 4'b0101;
         end else begin
            r.res = {s, 8'(ex), 23'(q)};
            r.flg = {3'b000, rem != 0};
         end
      end else begin
`ifdef FP_PACK_DENORM_EN
         longint half;
         int     sh;
         sh = 4 - ex;
         if (sh > 40) begin
            q    = 0;
            rem  = sig;
            half = longint'(1) << 40;
         end else begin
            q    = sig >> sh;
            rem  = sig - (q << sh);
            half = longint'(1) << (sh - 1);
         end
         if (rem > half || (rem == half && q % 2 == 1)) q++;
         r.res = {s, 31'(q)};
         r.flg = {2'b00, rem != 0, rem != 0};
`else
         r.res = {s, 31'h0};
         r.flg = 4'b0011;
`endif
      end
      return r;
   endfunction

   task automatic tick();
      @(negedge clk);
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (exp_stall) begin
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_out_valid", out_valid, 1'b1);
      end
      if (out_valid && held) chk("hold", {out_result, out_flags}, held_val);
      if (out_valid && q.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else if (out_valid) begin
         chk("result", out_result, q[0].res);
         chk("flags", out_flags, q[0].flg);
         if (out_ready) begin
            void'(q.pop_front());
            n_out++;
         end
      end
      held     = out_valid && !out_ready;
      held_val = {out_result, out_flags};
      if (in_valid && in_ready) q.push_back(model(in_sign, in_exp, in_mant, in_nan, in_inv, in_inf, in_zero));
      @(posedge clk);
      #1;
   endtask

   task automatic rand_in();
      int k;
      k       = $urandom_range(0, 99);
      in_sign = 1'($urandom);
      in_mant = {1'b1, 26'($urandom)};
      if ($urandom_range(0, 3) == 0) in_mant[2:0] = 3'b100;
      if ($urandom_range(0, 7) == 0) in_mant[25:3] = '1;
      {in_nan, in_inv, in_inf, in_zero} = 4'b0000;
      if (k < 35) in_exp = 10'($urandom_range(1, 254));
      else if (k < 50) in_exp = 10'($urandom_range(248, 262));
      else if (k < 72) in_exp = 10'd0 - 10'($urandom_range(0, 30));
      else if (k < 84) in_exp = 10'($urandom);
      else begin
         in_exp = 10'($urandom);
         {in_nan, in_inv, in_inf, in_zero} = 4'($urandom) | (4'b0001 << $urandom_range(0, 3));
      end
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      tick();
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic directed(input string tag, input logic s, input logic [9:0] e, input logic [26:0] m,
                           input logic [3:0] sp, input logic [31:0] want_res, input logic [3:0] want_flg);
      in_sign   = s;
      in_exp    = e;
      in_mant   = m;
      {in_nan, in_inv, in_inf, in_zero} = sp;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, out_valid, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({tag, "_lat2"}, out_valid, 1'b1);
      chk({tag, "_res"}, out_result, want_res);
      chk({tag, "_flg"}, out_flags, want_flg);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", out_result, 32'h0);
      chk("rst_flags", out_flags, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      directed("nan", 1'b1, 10'h155, 27'h5A5A5A5, 4'b1000, 32'h7FC0_0000, 4'b0000);
      directed("invalid", 1'b0, 10'h07F, 27'h4000000, 4'b0100, 32'h7FC0_0000, 4'b1000);
      directed("rne_up", 1'b0, 10'd127, {1'b1, 23'h000001, 3'b100}, 4'b0000, 32'h3F80_0002, 4'b0001);
      directed("rne_tie_even", 1'b0, 10'd127, {1'b1, 23'h000000, 3'b100}, 4'b0000, 32'h3F80_0000, 4'b0001);
      directed("overflow", 1'b0, 10'd254, {1'b1, 23'h7FFFFF, 3'b100}, 4'b0000, 32'h7F80_0000, 4'b0101);
`ifdef FP_PACK_DENORM_EN
      directed("tiny", 1'b0, 10'd0, {1'b1, 26'h0}, 4'b0000, 32'h0040_0000, 4'b0000);
`else
      directed("tiny", 1'b0, 10'd0, {1'b1, 26'h0}, 4'b0000, 32'h0000_0000, 4'b0011);
`endif
      directed("neg_inf", 1'b1, 10'd5, 27'h4000000, 4'b0010, 32'hFF80_0000, 4'b0000);
      directed("neg_zero", 1'b1, 10'd5, 27'h4000000, 4'b0001, 32'h8000_0000, 4'b0000);

      base      = n_out;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         rand_in();
         tick();
      end
      rand_in();
      out_ready = 1'b0;
      exp_stall = 1'b1;
      repeat (3) tick();
      exp_stall = 1'b0;
      out_ready = 1'b1;
      tick();
      drain();
      chk("stream_count", n_out - base, 5);

      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 9) < 7);
         rand_in();
         tick();
      end
      drain();

      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         rand_in();
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_result", out_result, 32'h0);
      chk("mid_rst_flags", out_flags, 4'h0);
      q.delete();
      held = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
         in_valid  = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 9) < 7);
         rand_in();
         tick();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
